// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds, sticky overflow / underflow flags
// and a synchronous flush.
//
// Optional build macro:
//   FIFO_FWFT_EN - first-word-fall-through read. rdata always shows the
//                  oldest stored word while rempty=0. Without the macro,
//                  rdata is a register that loads the head word on each
//                  accepted read (1-cycle latency) and otherwise holds.
//
// Ports:
//   clk           single clock, all state changes on the rising edge
//   rst           asynchronous, active-low reset
//   clear         synchronous flush, active-high, overrides winc/rinc
//   winc, wdata   write request and write data
//   rinc          read request
//   rdata         read data
//   wfull, rempty               full / empty flags
//   walmost_full, ralmost_empty count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module sync_fifo_flags #(
  parameter int DSIZE         = 8,
  parameter int ADDRESS_BITS  = 9,
  parameter int AFULL_THRESH  = 508,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    winc,
  input  logic [DSIZE-1:0]        wdata,
  input  logic                    rinc,
  output logic [DSIZE-1:0]        rdata,
  output logic                    wfull,
  output logic                    rempty,
  output logic                    walmost_full,
  output logic                    ralmost_empty,
  output logic [ADDRESS_BITS:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW    = ADDRESS_BITS + 1;
  localparam int DEPTH = 1 << ADDRESS_BITS;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          walmost_full_q, walmost_full_d;
  logic          ralmost_empty_q, ralmost_empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;
  logic mem_we;

  // Acceptance is decided from the registered flags seen at the edge, so a
  // simultaneous read cannot make room for a write into a full FIFO.
  assign wr_ok  = winc & ~wfull_q;
  assign rd_ok  = rinc & ~rempty_q;
  assign mem_we = wr_ok & ~clear;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      if (winc && wfull_q)  overflow_d  = 1'b1;
      if (rinc && rempty_q) underflow_d = 1'b1;
    end
    // The wrap bit makes the modular difference an exact 0..DEPTH count.
    count_d         = wptr_d - rptr_d;
    wfull_d         = (count_d == DEPTH_C);
    rempty_d        = (count_d == '0);
    walmost_full_d  = (count_d >= AFULL_C);
    ralmost_empty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

  // Storage array has no reset; stale words are unreachable once empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[ADDRESS_BITS-1:0]] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head word is read combinationally, so it appears as soon as the write
  // lands (one edge after the write) and the next word follows a pop on the
  // same edge the read pointer advances.
  assign rdata = mem[rptr_q[ADDRESS_BITS-1:0]];
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_ok && !clear) rdata_d = mem[rptr_q[ADDRESS_BITS-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = walmost_full_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (default parameters). A queue holds
// the expected FIFO contents; flags are derived from its size. Works with and
// without FIFO_FWFT_EN defined.
module tb_sync_fifo_flags;

  localparam int DEPTH = 512;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty;
  logic [9:0] count;
  logic       overflow, underflow;

  sync_fifo_flags dut (
    .clk(clk), .rst(rst), .clear(clear), .winc(winc), .wdata(wdata),
    .rinc(rinc), .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] obs_flags;
  assign obs_flags = {count, wfull, rempty, walmost_full, ralmost_empty, overflow, underflow};

  function automatic logic [15:0] exp_flags();
    int n;
    n = mq.size();
    return {10'(n), n == DEPTH, n == 0, n >= 508, n <= 4, m_ovf, m_unf};
  endfunction

  // Apply one cycle of stimulus, advance the model at the edge, return at the
  // following falling edge with inputs idle.
  task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit full, empty;
    logic [7:0] tmp;
    winc = w; wdata = d; rinc = r; clear = c;
    @(posedge clk);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (c) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (r && !empty) begin
        tmp = mq.pop_front();
        m_rdata = tmp;
      end
      if (w && !full) mq.push_back(d);
      if (w && full)  m_ovf = 1;
      if (r && empty) m_unf = 1;
    end
    @(negedge clk);
    winc = 0; rinc = 0; clear = 0;
  endtask

  task automatic test_reset();
    rst = 0; winc = 0; rinc = 0; clear = 0; wdata = '0;
    mq.delete(); m_ovf = 0; m_unf = 0; m_rdata = '0;
    #12;
    n_cmp++;
    if (obs_flags !== 16'b0000000000_0_1_0_1_0_0) begin
      n_bad++; $display("FAIL reset_flags: got %h want %h", obs_flags, 16'b0000000000_0_1_0_1_0_0);
    end
`ifndef FIFO_FWFT_EN
    n_cmp++;
    if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
`endif
    @(negedge clk); rst = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] pat [3];
    pat[0] = 8'hA1; pat[1] = 8'hA2; pat[2] = 8'hA3;
    for (int i = 0; i < 3; i++) drive(1, pat[i], 0, 0);
    n_cmp++;
    if (count !== 10'd3) begin n_bad++; $display("FAIL basic_count3: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
`ifdef FIFO_FWFT_EN
      n_cmp++;
      if (rdata !== pat[i]) begin n_bad++; $display("FAIL basic_head%0d: got %h want %h", i, rdata, pat[i]); end
      drive(0, 8'h00, 1, 0);
`else
      drive(0, 8'h00, 1, 0);
      n_cmp++;
      if (rdata !== pat[i]) begin n_bad++; $display("FAIL basic_rd%0d: got %h want %h", i, rdata, pat[i]); end
`endif
    end
    n_cmp++;
    if (count !== 10'd0 || rempty !== 1'b1) begin
      n_bad++; $display("FAIL basic_empty: got count %0d rempty %b want 0 1", count, rempty);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] first_w, d;
    first_w = 8'($urandom_range(0, 254));
    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 0) ? first_w : 8'($urandom_range(0, 254));
      drive(1, d, 0, 0);
      n_cmp++;
      if (obs_flags !== exp_flags()) begin
        n_bad++; $display("FAIL fill_flags@%0d: got %h want %h", i + 1, obs_flags, exp_flags());
      end
    end
    drive(1, 8'hFF, 0, 0);
    n_cmp++;
    if (count !== 10'd512 || wfull !== 1'b1 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_write: got count %0d wfull %b ovf %b want 512 1 1", count, wfull, overflow);
    end
    drive(1, 8'hFF, 1, 0);
    n_cmp++;
    if (count !== 10'd511 || wfull !== 1'b0 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL full_rw: got count %0d wfull %b ovf %b want 511 0 1", count, wfull, overflow);
    end
`ifndef FIFO_FWFT_EN
    n_cmp++;
    if (rdata !== first_w) begin n_bad++; $display("FAIL full_rw_data: got %h want %h", rdata, first_w); end
`endif
    while (mq.size() > 0) begin
`ifdef FIFO_FWFT_EN
      n_cmp++;
      if (rdata !== mq[0] || rdata === 8'hFF) begin
        n_bad++; $display("FAIL drain_head: got %h want %h", rdata, mq[0]);
      end
      drive(0, 8'h00, 1, 0);
`else
      drive(0, 8'h00, 1, 0);
      n_cmp++;
      if (rdata !== m_rdata || rdata === 8'hFF) begin
        n_bad++; $display("FAIL drain_data: got %h want %h", rdata, m_rdata);
      end
`endif
    end
    n_cmp++;
    if (obs_flags !== exp_flags()) begin
      n_bad++; $display("FAIL drain_flags: got %h want %h", obs_flags, exp_flags());
    end
  endtask

  task automatic test_empty_rw();
    drive(1, 8'h5C, 1, 0);
    n_cmp++;
    if (count !== 10'd1 || underflow !== 1'b1 || rempty !== 1'b0) begin
      n_bad++; $display("FAIL empty_rw: got count %0d unf %b rempty %b want 1 1 0", count, underflow, rempty);
    end
`ifdef FIFO_FWFT_EN
    n_cmp++;
    if (rdata !== 8'h5C) begin n_bad++; $display("FAIL empty_rw_head: got %h want 5c", rdata); end
    drive(0, 8'h00, 1, 0);
`else
    drive(0, 8'h00, 1, 0);
    n_cmp++;
    if (rdata !== 8'h5C) begin n_bad++; $display("FAIL empty_rw_data: got %h want 5c", rdata); end
`endif
  endtask

  task automatic test_clear();
    logic [7:0] held;
    drive(1, 8'h01, 0, 0);
    drive(0, 8'h00, 1, 0);
    held = rdata;
    for (int i = 0; i < 99; i++) drive(1, 8'($urandom), 0, 0);
    drive(1, 8'h00, 0, 0);
    drive(1, 8'h00, 0, 0); // 101st push: spare word, count now 101
    drive(0, 8'h00, 1, 1); // overflow/underflow remain from earlier; read is overridden
    drive(1, 8'hEE, 0, 1);
    n_cmp++;
    if (obs_flags !== 16'b0000000000_0_1_0_1_0_0) begin
      n_bad++; $display("FAIL clear_flags: got %h want %h", obs_flags, 16'b0000000000_0_1_0_1_0_0);
    end
`ifndef FIFO_FWFT_EN
    n_cmp++;
    if (rdata !== held) begin n_bad++; $display("FAIL clear_rdata_hold: got %h want %h", rdata, held); end
`endif
    drive(1, 8'h3C, 1, 0);
    n_cmp++;
    if (obs_flags !== exp_flags()) begin
      n_bad++; $display("FAIL post_clear: got %h want %h", obs_flags, exp_flags());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) drive(1, 8'($urandom), (i % 3) == 0, 0);
    drive(1, 8'h00, 1, 0);
    winc = 1; wdata = 8'h77;
    #2 rst = 0;
    #1;
    n_cmp++;
    if (obs_flags !== 16'b0000000000_0_1_0_1_0_0) begin
      n_bad++; $display("FAIL async_rst_flags: got %h want %h", obs_flags, 16'b0000000000_0_1_0_1_0_0);
    end
`ifndef FIFO_FWFT_EN
    n_cmp++;
    if (rdata !== 8'h00) begin n_bad++; $display("FAIL async_rst_rdata: got %h want 00", rdata); end
`endif
    winc = 0;
    mq.delete(); m_ovf = 0; m_unf = 0; m_rdata = '0;
    @(negedge clk); rst = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 3000; i++) begin
      if (((i / 750) % 2) == 0) begin
        w = ($urandom_range(0, 9) < 9); r = ($urandom_range(0, 9) < 2);
      end else begin
        w = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 9);
      end
      c = ($urandom_range(0, 499) == 0);
`ifdef FIFO_FWFT_EN
      if (mq.size() > 0) begin
        n_cmp++;
        if (rdata !== mq[0]) begin n_bad++; $display("FAIL rand_head@%0d: got %h want %h", i, rdata, mq[0]); end
      end
`endif
      drive(w, 8'($urandom), r, c);
      n_cmp++;
      if (obs_flags !== exp_flags()) begin
        n_bad++; $display("FAIL rand_flags@%0d: got %h want %h", i, obs_flags, exp_flags());
      end
`ifndef FIFO_FWFT_EN
      n_cmp++;
      if (rdata !== m_rdata) begin n_bad++; $display("FAIL rand_data@%0d: got %h want %h", i, rdata, m_rdata); end
`endif
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    n_cmp++;
    if (rdata !== 8'h11 || rempty !== 1'b0) begin
      n_bad++; $display("FAIL fwft_head: got %h rempty %b want 11 0", rdata, rempty);
    end
    drive(0, 8'h00, 1, 0);
    n_cmp++;
    if (rdata !== 8'h22) begin n_bad++; $display("FAIL fwft_pop: got %h want 22", rdata); end
    drive(0, 8'h00, 1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_empty_rw();
    test_clear();
    test_async_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
